// File: rtl/seq_detector_param_if.sv
// Serial detector bus: qualified bit stream and pattern/counter control in,
// registered match pulse, progress and match count out.
interface seq_detector_param_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    localparam int ST_W = $clog2(PAT_W + 1);

    logic             x;
    logic             x_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             z;
    logic [ST_W-1:0]  state;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        input  z, state, match_cnt
    );

    modport slave (
        input  x, x_valid, overlap, pat_load, pat_in, cnt_clr,
        output z, state, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and saturating match count.
// Latency: z/state registered one cycle after the sampling edge; no backpressure, x_valid qualifies each bit.
module seq_detector_param #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int               CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);
    localparam int               ST_W    = $clog2(PAT_W + 1);
    localparam logic [ST_W-1:0]  FULL    = ST_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] history;
    logic [ST_W-1:0]  fill;
    logic [ST_W-1:0]  st_q;
    logic             z_q;
    logic [CNT_W-1:0] cnt_q;

    logic [PAT_W-1:0] hist_nxt;
    logic [ST_W-1:0]  fill_nxt;
    logic [ST_W-1:0]  k_nxt;
    logic             hit;
    logic             bump;
    logic [CNT_W-1:0] cnt_base;

    // Progress is the longest pattern prefix that is also a suffix of the
    // bits seen since restart; fill caps how far back history is trusted.
    always_comb begin
        hist_nxt = {history[PAT_W-2:0], bus.x};
        fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
        k_nxt    = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            if ((ST_W'(k) <= fill_nxt) &&
                (((hist_nxt ^ (pattern >> (PAT_W - k))) &
                  ({PAT_W{1'b1}} >> (PAT_W - k))) == '0)) begin
                k_nxt = ST_W'(k);
            end
        end
        hit      = (k_nxt == FULL);
        bump     = bus.x_valid && !bus.pat_load && hit;
        cnt_base = bus.cnt_clr ? '0 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= PATTERN;
            history <= '0;
            fill    <= '0;
            st_q    <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            z_q <= 1'b0;
            if (bus.pat_load) begin
                pattern <= bus.pat_in;
                fill    <= '0;
                st_q    <= '0;
            end else if (bus.x_valid) begin
                history <= hist_nxt;
                // Non-overlap: state shows the full match this cycle, the next
                // sample then starts from an empty history.
                fill    <= (hit && !bus.overlap) ? '0 : fill_nxt;
                st_q    <= k_nxt;
                z_q     <= hit;
            end
            cnt_q <= (bump && (cnt_base != CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
        end
    end

    assign bus.z         = z_q;
    assign bus.state     = st_q;
    assign bus.match_cnt = cnt_q;
endmodule
